pu_layer_scheduler: RTL and testbench

//  Sequences one layer pass through the 4-input floating-point processing unit (4 mults -> reg -> adder tree -> reg).
//  Per cycle it issues one neuron index to the weight/input bank and tracks it through the fixed PU pipeline.
//  It writes each PU result to the result bank at that neuron's index, then pulses done.

---
 rtl/pu_sched_pkg.sv | 13 +
 rtl/pu_layer_scheduler_tag_pipe.sv | 42 ++++
 rtl/pu_layer_scheduler.sv | 120 ++++++++++++
 tb/tb_pu_layer_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_sched_pkg.sv
// Constants and state encoding shared by the layer scheduler and the PU wrapper.
package pu_sched_pkg;

  localparam int unsigned PU_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pu_layer_scheduler_tag_pipe.sv
// Tracks issued neuron indices through the fixed-latency PU pipeline.
module pu_tag_pipe #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_idx,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_idx
);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    vld_d    = '0;
    idx_d    = '0;
    vld_d[0] = in_valid;
    idx_d[0] = in_idx;
    for (int i = 1; i < int'(DEPTH); i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // The PU never stalls, so the pipe advances unconditionally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/pu_layer_scheduler.sv
// Issues one neuron index per cycle to the PU for a layer pass and writes results back by index.
module pu_layer_scheduler #(
  parameter int unsigned XLEN       = 5,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned PU_LATENCY = pu_sched_pkg::PU_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] neuron_count,
  output logic              busy,
  output logic              done,
  output logic              op_rd,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [XLEN-1:0]   pu_result,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [XLEN-1:0]   res_data
);

  import pu_sched_pkg::*;

  localparam int unsigned DCNT_W = (PU_LATENCY > 1) ? $clog2(PU_LATENCY) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   n_q, n_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic [DCNT_W-1:0]   drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                op_rd_q, op_rd_d;

  // Next-state logic; outputs are decoded from the next state so they land registered.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    op_rd_d   = 1'b0;
    op_addr_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d   = neuron_count;
          idx_d = '0;
          if (neuron_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            op_rd_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // Compare in ADDR_W bits so a full 2**ADDR_W-1 pass stops before idx wraps.
        if (idx_q == n_q - ADDR_W'(1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          idx_d     = idx_q + ADDR_W'(1);
          op_rd_d   = 1'b1;
          op_addr_d = idx_d;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DCNT_W'(PU_LATENCY - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DCNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      op_addr_q <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_rd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      op_addr_q <= op_addr_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      op_rd_q   <= op_rd_d;
    end
  end

  pu_tag_pipe #(
    .ADDR_W (ADDR_W),
    .DEPTH  (PU_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (op_rd_q),
    .in_idx    (op_addr_q),
    .out_valid (res_we),
    .out_idx   (res_addr)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign op_rd    = op_rd_q;
  assign op_addr  = op_addr_q;
  assign res_data = pu_result;

endmodule

// File: tb/tb_pu_layer_scheduler.sv
// Bench for pu_layer_scheduler: a behavioural PU with random operand banks plus a cycle-schedule reference.
module tb_pu_layer_scheduler;

  localparam int unsigned XLEN   = 5;
  localparam int unsigned ADDR_W = 4;
  localparam int          LAT    = int'(pu_sched_pkg::PU_LATENCY);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] neuron_count;
  logic              busy, done, op_rd, res_we;
  logic [ADDR_W-1:0] op_addr, res_addr;
  logic [XLEN-1:0]   pu_result, res_data;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] wmem [16][4];
  logic [XLEN-1:0] xmem [16][4];
  logic [XLEN-1:0] p_q [4];
  logic [XLEN-1:0] s_q;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              op_rd;
    logic [ADDR_W-1:0] op_addr;
    logic              res_we;
    logic [ADDR_W-1:0] res_addr;
  } ctl_t;

  always #5 clk = ~clk;

  pu_layer_scheduler #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .neuron_count (neuron_count),
    .busy         (busy),
    .done         (done),
    .op_rd        (op_rd),
    .op_addr      (op_addr),
    .pu_result    (pu_result),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .res_data     (res_data)
  );

  // PU stand-in: bank read combinationally at op_addr, 4 multipliers -> reg -> adder tree -> reg.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) p_q[k] <= '0;
      s_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) p_q[k] <= XLEN'(wmem[op_addr][k] * xmem[op_addr][k]);
      s_q <= XLEN'(p_q[0] + p_q[1] + p_q[2] + p_q[3]);
    end
  end
  assign pu_result = s_q;

  function automatic logic [XLEN-1:0] dot(input int a);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(wmem[a][k]) * int'(xmem[a][k]);
    return XLEN'(s);
  endfunction

  // Expected outputs in cycle c of a pass of n neurons whose start was sampled in cycle 0.
  function automatic ctl_t exp_ctl(input int n, input int c);
    ctl_t e = '0;
    int   d = (n == 0) ? 1 : n + LAT + 1;
    e.busy   = (c >= 1) && (c <= d);
    e.done   = (c == d);
    e.op_rd  = (n > 0) && (c >= 1) && (c <= n);
    e.res_we = (n > 0) && (c >= 1 + LAT) && (c <= n + LAT);
    if (e.op_rd)  e.op_addr  = ADDR_W'(c - 1);
    if (e.res_we) e.res_addr = ADDR_W'(c - 1 - LAT);
    return e;
  endfunction

  // Addresses are only meaningful while their strobe is expected.
  function automatic ctl_t obs_ctl(input ctl_t e);
    ctl_t o;
    o.busy     = busy;
    o.done     = done;
    o.op_rd    = op_rd;
    o.op_addr  = e.op_rd ? op_addr : '0;
    o.res_we   = res_we;
    o.res_addr = e.res_we ? res_addr : '0;
    return o;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_banks();
    for (int a = 0; a < 16; a++)
      for (int k = 0; k < 4; k++) begin
        wmem[a][k] = XLEN'($urandom);
        xmem[a][k] = XLEN'($urandom);
      end
  endtask

  task automatic test_reset();
    ctl_t e, o;
    rst = 1'b1;
    start = 1'b0;
    neuron_count = '0;
    fill_banks();
    repeat (3) next_cycle();
    e = '0;
    o = obs_ctl(e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", o, e);
    end
    checks++;
    if (res_data !== '0) begin
      errors++;
      $display("FAIL reset_res_data: got %h want 0", res_data);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  // One pass of n neurons; checks every output cycle by cycle and every written result.
  task automatic test_pass(input int n, input string name);
    ctl_t e, o;
    int   d = (n == 0) ? 1 : n + LAT + 1;
    fill_banks();
    start = 1'b1;
    neuron_count = ADDR_W'(n);
    for (int c = 1; c <= d + 2; c++) begin
      next_cycle();
      start = 1'b0;
      neuron_count = ADDR_W'($urandom);
      e = exp_ctl(n, c);
      o = obs_ctl(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s ctl n=%0d cyc=%0d: got %h want %h", name, n, c, o, e);
      end
      if (e.res_we) begin
        checks++;
        if (res_data !== dot(int'(e.res_addr))) begin
          errors++;
          $display("FAIL %s data n=%0d addr=%0d: got %h want %h",
                   name, n, e.res_addr, res_data, dot(int'(e.res_addr)));
        end
      end
    end
  endtask

  // start stays high through the pass while neuron_count wanders; the next pass starts from IDLE.
  task automatic test_start_held();
    ctl_t e, o;
    int   d1 = 3 + LAT + 1;
    int   d2 = 2 + LAT + 1;
    fill_banks();
    start = 1'b1;
    neuron_count = ADDR_W'(3);
    for (int c = 1; c <= d1 + 1; c++) begin
      next_cycle();
      neuron_count = (c == d1 + 1) ? ADDR_W'(2) : ADDR_W'($urandom);
      e = exp_ctl(3, c);
      o = obs_ctl(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_held first cyc=%0d: got %h want %h", c, o, e);
      end
    end
    for (int c = 1; c <= d2 + 2; c++) begin
      next_cycle();
      start = 1'b0;
      e = exp_ctl(2, c);
      o = obs_ctl(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_held second cyc=%0d: got %h want %h", c, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    ctl_t e, o;
    fill_banks();
    start = 1'b1;
    neuron_count = ADDR_W'(5);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      start = 1'b0;
      e = exp_ctl(5, c);
      o = obs_ctl(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_mid pre cyc=%0d: got %h want %h", c, o, e);
      end
    end
    rst = 1'b1;
    #1;
    e = '0;
    o = obs_ctl(e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL rst_mid immediate: got %h want %h", o, e);
    end
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      o = obs_ctl(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_mid after cyc=%0d: got %h want %h", c, o, e);
      end
    end
    test_pass(1, "rst_mid_restart");
  endtask

  task automatic test_scoreboard();
    for (int i = 0; i < 8; i++) test_pass($urandom_range(0, 15), "random");
  endtask

  initial begin
    test_reset();
    test_pass(3, "basic_n3");
    test_pass(0, "zero_n");
    test_pass(15, "max_n");
    test_start_held();
    test_reset_mid_pass();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
